// File: rtl/nanov_peripherals.sv
// nanov_peripherals: memory-mapped GPIO, UART channels and an optional timer
// for the nanoV CPU bus. The timer is only built when NANOV_PERI_TIMER_EN is
// defined; otherwise its offsets decode as unmapped and timer_irq is tied low.

module uart_tx #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bits_q, bits_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign busy = (bits_q != 4'd0);
  assign txd  = shift_q[0];

  // Load a start/data/stop frame when idle, then shift one bit per bit period
  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (start) begin
        shift_d = {1'b1, data, 1'b0};
        bits_d  = 4'd10;
        cnt_d   = CW'(CLKS_PER_BIT - 1);
      end
    end else if (cnt_q == '0) begin
      shift_d = {1'b1, shift_q[9:1]};
      bits_d  = bits_q - 4'd1;
      cnt_d   = CW'(CLKS_PER_BIT - 1);
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Idle line is high, so reset fills the shifter with ones
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_q <= '1;
      bits_q  <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module uart_rx #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       read,
  output logic [7:0] data,
  output logic       valid,
  output logic       rts
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic          rx1_q, rx1_d, rx2_q, rx2_d;
  logic          active_q, active_d;
  logic [3:0]    bits_q, bits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;

  assign data  = data_q;
  assign valid = valid_q;
  // Hold off the sender while an unread byte is pending
  assign rts   = valid_q;

  // Sample mid-bit: half a period after the start edge, then every full period
  always_comb begin
    rx1_d    = rxd;
    rx2_d    = rx1_q;
    active_d = active_q;
    bits_d   = bits_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q & ~read;
    if (!active_q) begin
      if (!rx2_q) begin
        active_d = 1'b1;
        bits_d   = 4'd0;
        cnt_d    = CW'(CLKS_PER_BIT / 2 - 1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d  = CW'(CLKS_PER_BIT - 1);
      bits_d = bits_q + 4'd1;
      if (bits_q == 4'd0) begin
        // A high line at mid start bit was a glitch
        if (rx2_q) active_d = 1'b0;
      end else if (bits_q == 4'd9) begin
        active_d = 1'b0;
        if (rx2_q) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end else begin
        shift_d = {rx2_q, shift_q[7:1]};
      end
    end
  end

  // Receiver state; reset discards any partial or pending byte
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx1_q    <= 1'b1;
      rx2_q    <= 1'b1;
      active_q <= 1'b0;
      bits_q   <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rx1_q    <= rx1_d;
      rx2_q    <= rx2_d;
      active_q <= active_d;
      bits_q   <= bits_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end
endmodule

module nanov_peripherals #(
  parameter logic [31:0] BASE_ADDR      = 32'h10000000,
  parameter int          GPIO_OUT_WIDTH = 32,
  parameter int          GPIO_IN_WIDTH  = 3,
  parameter int          NUM_UARTS      = 1,
  parameter int          CLK_HZ         = 12_000_000,
  parameter int          BIT_RATE       = 93_750
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      is_addr,
  input  logic                      is_data,
  input  logic                      is_data_in,
  input  logic [31:0]               data_out,
  output logic [31:0]               data_in,
  output logic [GPIO_OUT_WIDTH-1:0] gpio_out,
  input  logic [GPIO_IN_WIDTH-1:0]  gpio_in,
  output logic [NUM_UARTS-1:0]      uart_txd,
  input  logic [NUM_UARTS-1:0]      uart_rxd,
  output logic [NUM_UARTS-1:0]      uart_rts,
  output logic                      timer_irq
);
  // UART n data is SEL_UART+2n, status is SEL_UART+2n+1
  localparam logic [4:0] SEL_NONE  = 5'd0;
  localparam logic [4:0] SEL_GOUT  = 5'd1;
  localparam logic [4:0] SEL_GSET  = 5'd2;
  localparam logic [4:0] SEL_GCLR  = 5'd3;
  localparam logic [4:0] SEL_GIN   = 5'd4;
  localparam logic [4:0] SEL_UART  = 5'd8;
  localparam logic [4:0] SEL_TCNT  = 5'd16;
  localparam logic [4:0] SEL_TCMP  = 5'd17;
  localparam logic [4:0] SEL_TSTAT = 5'd18;
  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;

  logic [31:0]               wdata, off;
  logic [4:0]                sel_q, sel_d, sel_dec;
  logic [GPIO_OUT_WIDTH-1:0] gpio_q, gpio_d;
  logic [GPIO_IN_WIDTH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_UARTS-1:0]      tx_start, tx_busy, rx_read, rx_valid;
  logic [7:0]                rx_data [NUM_UARTS];

  assign off      = data_out - BASE_ADDR;
  assign gpio_out = gpio_q;

  // Write data arrives bit-reversed on the bus
  always_comb begin
    wdata = '0;
    for (int i = 0; i < 32; i++) wdata[i] = data_out[31 - i];
  end

  // Decode the bus address into a select code that holds until the next address
  always_comb begin
    sel_dec = SEL_NONE;
    case (off)
      32'h00:  sel_dec = SEL_GOUT;
      32'h04:  sel_dec = SEL_GSET;
      32'h08:  sel_dec = SEL_GCLR;
      32'h0C:  sel_dec = SEL_GIN;
`ifdef NANOV_PERI_TIMER_EN
      32'h30:  sel_dec = SEL_TCNT;
      32'h34:  sel_dec = SEL_TCMP;
      32'h38:  sel_dec = SEL_TSTAT;
`endif
      default: sel_dec = SEL_NONE;
    endcase
    for (int n = 0; n < NUM_UARTS; n++) begin
      if (off == 32'(32'h10 + 8 * n)) sel_dec = 5'(SEL_UART + 2 * n);
      if (off == 32'(32'h14 + 8 * n)) sel_dec = 5'(SEL_UART + 2 * n + 1);
    end
    sel_d = is_addr ? sel_dec : sel_q;
  end

  // GPIO output register with set/clear aliases, plus the input synchroniser
  always_comb begin
    gpio_d  = gpio_q;
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    if (is_data) begin
      case (sel_q)
        SEL_GOUT: gpio_d = wdata[GPIO_OUT_WIDTH-1:0];
        SEL_GSET: gpio_d = gpio_q | wdata[GPIO_OUT_WIDTH-1:0];
        SEL_GCLR: gpio_d = gpio_q & ~wdata[GPIO_OUT_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  // Bus select and GPIO state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sel_q   <= SEL_NONE;
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sel_q   <= sel_d;
      gpio_q  <= gpio_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar n = 0; n < NUM_UARTS; n++) begin : g_uart
    // A TX write while busy is dropped rather than queued
    assign tx_start[n] = is_data && (sel_q == 5'(SEL_UART + 2 * n)) && !tx_busy[n];
    assign rx_read[n]  = is_data_in && (sel_q == 5'(SEL_UART + 2 * n));

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk(clk), .rstn(rstn), .start(tx_start[n]), .data(wdata[7:0]),
      .txd(uart_txd[n]), .busy(tx_busy[n])
    );
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk(clk), .rstn(rstn), .rxd(uart_rxd[n]), .read(rx_read[n]),
      .data(rx_data[n]), .valid(rx_valid[n]), .rts(uart_rts[n])
    );
  end

`ifdef NANOV_PERI_TIMER_EN
  logic [31:0] count_q, count_d, cmp_q, cmp_d;
  logic        flag_q, flag_d;

  assign timer_irq = flag_q;

  // Free-running counter; software writes beat the increment, a match beats a clear
  always_comb begin
    count_d = count_q + 32'd1;
    cmp_d   = cmp_q;
    flag_d  = flag_q;
    if (is_data && sel_q == SEL_TCNT) count_d = wdata;
    if (is_data && sel_q == SEL_TCMP) cmp_d = wdata;
    if (is_data && sel_q == SEL_TSTAT && wdata[0]) flag_d = 1'b0;
    if (count_q == cmp_q) flag_d = 1'b1;
  end

  // Timer state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
      cmp_q   <= '1;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // Combinational read mux; unmapped selects read as zero
  always_comb begin
    data_in = '0;
    case (sel_q)
      SEL_GOUT, SEL_GSET, SEL_GCLR: data_in[GPIO_OUT_WIDTH-1:0] = gpio_q;
      SEL_GIN:   data_in[GPIO_IN_WIDTH-1:0] = sync2_q;
`ifdef NANOV_PERI_TIMER_EN
      SEL_TCNT:  data_in = count_q;
      SEL_TCMP:  data_in = cmp_q;
      SEL_TSTAT: data_in = {31'b0, flag_q};
`endif
      default:   ;
    endcase
    for (int n = 0; n < NUM_UARTS; n++) begin
      if (sel_q == 5'(SEL_UART + 2 * n))     data_in = {24'b0, rx_data[n]};
      if (sel_q == 5'(SEL_UART + 2 * n + 1)) data_in = {30'b0, rx_valid[n], tx_busy[n]};
    end
  end
endmodule

// File: tb/tb_nanov_peripherals.sv
// Directed bench for nanov_peripherals with two UART channels; channel 0 is
// looped back from txd to rxd. Timer checks follow NANOV_PERI_TIMER_EN.

module tb_nanov_peripherals;
  localparam logic [31:0] BASE = 32'h10000000;

  logic        clk = 1'b0;
  logic        rstn, is_addr, is_data, is_data_in;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic [31:0] gpio_out;
  logic [2:0]  gpio_in;
  logic [1:0]  uart_txd, uart_rxd, uart_rts;
  logic        timer_irq;

  int cyc = 0;
  int checks = 0, passed = 0, fails = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  nanov_peripherals #(.NUM_UARTS(2)) dut (
    .clk(clk), .rstn(rstn), .is_addr(is_addr), .is_data(is_data),
    .is_data_in(is_data_in), .data_out(data_out), .data_in(data_in),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .uart_txd(uart_txd),
    .uart_rxd(uart_rxd), .uart_rts(uart_rts), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign uart_rxd = {1'b1, uart_txd[0]};

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic bus_addr(input logic [31:0] a);
    @(negedge clk);
    is_addr = 1'b1; data_out = a;
    @(negedge clk);
    is_addr = 1'b0; data_out = '0;
  endtask

  task automatic bus_data(input logic [31:0] v);
    is_data = 1'b1; data_out = rev32(v);
    @(negedge clk);
    is_data = 1'b0; data_out = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    bus_addr(a);
    bus_data(v);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int t0, t1, t2, n;
    logic [7:0] txb;
    rstn = 1'b0; is_addr = 1'b0; is_data = 1'b0; is_data_in = 1'b0;
    data_out = '0; gpio_in = 3'b000;
    repeat (3) @(negedge clk);

    expect_val("rst_gpio_out", 32'h0);   check(gpio_out);
    expect_val("rst_data_in", 32'h0);    check(data_in);
    expect_val("rst_uart_txd", 32'h3);   check({30'b0, uart_txd});
    expect_val("rst_uart_rts", 32'h0);   check({30'b0, uart_rts});
    expect_val("rst_timer_irq", 32'h0);  check({31'b0, timer_irq});
    rstn = 1'b1;

    // GPIO output, set and clear aliases
    expect_val("gpio_write", 32'hA5);  bus_write(BASE, 32'hA5);          check(gpio_out);
    expect_val("gpio_set", 32'h1A5);   bus_write(BASE + 32'h4, 32'h100); check(gpio_out);
    expect_val("gpio_clr", 32'h1A0);   bus_write(BASE + 32'h8, 32'h5);   check(gpio_out);
    expect_val("gpio_clr_readback", 32'h1A0);                            check(data_in);
    expect_val("write_none_ignored", 32'h1A0);
    bus_write(BASE + 32'h40, 32'hFFFF_FFFF);                             check(gpio_out);
    expect_val("read_none", 32'h0);                                      check(data_in);
    expect_val("write_ro_ignored", 32'h1A0);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);                              check(gpio_out);

    // GPIO input synchroniser latency; GPIO_IN is still selected
    gpio_in = 3'b101;
    expect_val("gpio_in_lat1", 32'h0); @(negedge clk); check(data_in);
    expect_val("gpio_in_lat2", 32'h5); @(negedge clk); check(data_in);

    // UART1 transmit, busy status, dropped second write
    txb = 8'h55;
    bus_write(BASE + 32'h18, 32'h55);
    t0 = cyc;
    bus_addr(BASE + 32'h1C);
    expect_val("tx1_busy_status", 32'h1); check(data_in);
    bus_write(BASE + 32'h18, 32'h00);
    for (int k = 0; k < 10; k++) begin
      wait_until(t0 + 128 * k + 64);
      if (k == 0)      expect_val("tx1_start_bit", 32'h0);
      else if (k == 9) expect_val("tx1_stop_bit", 32'h1);
      else             expect_val("tx1_data_bit", {31'b0, txb[k-1]});
      check({31'b0, uart_txd[1]});
    end
    wait_until(t0 + 1282);
    bus_addr(BASE + 32'h1C);
    expect_val("tx1_idle_status", 32'h0); check(data_in);
    for (int k = 0; k < 4; k++) begin
      wait_until(t0 + 1280 + 128 * k + 64);
      expect_val("tx1_dropped_idle", 32'h1); check({31'b0, uart_txd[1]});
    end

    // UART0 loopback receive and read-clear
    bus_write(BASE + 32'h10, 32'h3C);
    t1 = cyc;
    wait_until(t1 + 1400);
    expect_val("rx0_rts", 32'h1); check({31'b0, uart_rts[0]});
    bus_addr(BASE + 32'h14);
    expect_val("rx0_status_valid", 32'h2); check(data_in);
    bus_addr(BASE + 32'h10);
    is_data_in = 1'b1;
    expect_val("rx0_data", 32'h3C); check(data_in);
    @(negedge clk);
    is_data_in = 1'b0;
    bus_addr(BASE + 32'h14);
    expect_val("rx0_status_cleared", 32'h0); check(data_in);

`ifdef NANOV_PERI_TIMER_EN
    bus_write(BASE + 32'h30, 32'd100);
    bus_write(BASE + 32'h34, 32'd20);
    bus_addr(BASE + 32'h30);
    expect_val("irq_before", 32'h0); check({31'b0, timer_irq});
    bus_data(32'd0);
    t2 = cyc;
    n = 0;
    while (!timer_irq && n < 100) begin
      @(negedge clk);
      n++;
    end
    expect_val("irq_latency", 32'd21); check(32'(cyc - t2));
    bus_write(BASE + 32'h38, 32'h1);
    expect_val("irq_clear", 32'h0); check({31'b0, timer_irq});
    bus_addr(BASE + 32'h34);
    expect_val("cmp_read", 32'd20); check(data_in);
    bus_addr(BASE + 32'h30);
    bus_data(32'hFFFF_FFFF);
    expect_val("count_max", 32'hFFFF_FFFF); check(data_in);
    @(negedge clk);
    expect_val("count_wrap", 32'h0); check(data_in);
`else
    bus_addr(BASE + 32'h30);
    expect_val("timer_count_absent", 32'h0); check(data_in);
    bus_write(BASE + 32'h34, 32'd5);
    bus_write(BASE + 32'h30, 32'd0);
    repeat (30) @(negedge clk);
    expect_val("timer_irq_absent", 32'h0); check({31'b0, timer_irq});
`endif

    // Reset in the middle of activity
    bus_write(BASE, 32'hFF);
    bus_write(BASE + 32'h10, 32'h81);
    t1 = cyc;
    wait_until(t1 + 1400);
    expect_val("rx0_pending_rts", 32'h1); check({31'b0, uart_rts[0]});
    bus_write(BASE + 32'h18, 32'h00);
    t0 = cyc;
    bus_addr(BASE + 32'hC);
    expect_val("pre_reset_data_in", 32'h5); check(data_in);
    wait_until(t0 + 200);
    expect_val("tx1_mid_frame", 32'h0); check({31'b0, uart_txd[1]});
    rstn = 1'b0;
    @(negedge clk);
    expect_val("mid_rst_uart_txd", 32'h3);  check({30'b0, uart_txd});
    expect_val("mid_rst_gpio_out", 32'h0);  check(gpio_out);
    expect_val("mid_rst_data_in", 32'h0);   check(data_in);
    expect_val("mid_rst_uart_rts", 32'h0);  check({30'b0, uart_rts});
    expect_val("mid_rst_timer_irq", 32'h0); check({31'b0, timer_irq});
    rstn = 1'b1;
    bus_addr(BASE + 32'h14);
    expect_val("rx0_discarded", 32'h0); check(data_in);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
